alarm_ctrl: RTL and testbench
=============================

ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 100: cycles in ACTIVE without ack before escalation; legal range 1..65535.
REQ-002 Parameter HOLDOFF, default 16: cycles spent in HOLD before re-arming; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  One clock; reset is asynchronous and active-low.
REQ-005 alarm  input  1  level alarm from the upstream threshold monitor, synchronous to clk.
REQ-006 ack  input  1  operator acknowledge, single-cycle or level, synchronous to clk.
REQ-007 en  input  1  block enable; low forces IDLE.
REQ-008 clr_cnt  input  1  synchronous clear of alarm_cnt.
REQ-009 buzz  output  1  alarm annunciator, high in ACTIVE and ESCAL.
REQ-010 escalate  output  1  high in ESCAL only.
REQ-011 alarm_cnt  output  8  number of alarms raised, saturating.
REQ-012 state  output  3  current state encoding: IDLE=0, ACTIVE=1, ESCAL=2, ACKED=3, HOLD=4.

Function
REQ-013 The block SHALL be a Moore FSM with registered state; buzz, escalate and state SHALL be decoded from the state register only.
REQ-014 IDLE: en=1 and alarm=1 at an edge SHALL move to ACTIVE, clear the timer and increment alarm_cnt; otherwise stay IDLE.
REQ-015 Latency: buzz SHALL rise on the first edge at which alarm=1 is sampled in IDLE (one-cycle latency).
REQ-016 ACTIVE: ack=1 SHALL move to ACKED; else timer==TIMEOUT-1 SHALL move to ESCAL; else timer increments by 1.
REQ-017 ACTIVE SHALL be latched: alarm falling before ack SHALL NOT leave ACTIVE.
REQ-018 ack and timeout in the same cycle: ack SHALL win (next state ACKED, escalate never asserts).
REQ-019 escalate SHALL therefore assert exactly TIMEOUT cycles after buzz rises when no ack arrives.
REQ-020 ESCAL: ack=1 SHALL move to ACKED; otherwise remain ESCAL indefinitely.
REQ-021 ACKED: buzz=0, escalate=0; alarm=0 SHALL move to HOLD with the timer cleared; alarm=1 SHALL stay ACKED.
REQ-022 HOLD: timer increments; timer==HOLDOFF-1 SHALL move to IDLE; alarm is ignored in HOLD.
REQ-023 Alarm still or again high on return to IDLE SHALL retrigger ACTIVE on the next edge (new count).
REQ-024 en=0 in any state SHALL force next state IDLE and clear the timer; alarm_cnt SHALL be retained.
REQ-025 Timer SHALL be 16 bits, reused for the ACTIVE timeout and the HOLD interval, cleared on every state change.
REQ-026 alarm_cnt SHALL saturate at 255; an alarm raised at 255 leaves it at 255.
REQ-027 clr_cnt=1 SHALL load alarm_cnt with 0 on the next edge, taking priority over a simultaneous increment.
REQ-028 ack in IDLE, ACKED or HOLD SHALL have no effect.

Reset
REQ-029 rst=0 SHALL asynchronously force state=IDLE, timer=0, alarm_cnt=0, buzz=0, escalate=0, regardless of clk.
REQ-030 Reset asserted mid-ACTIVE or mid-ESCAL SHALL drop buzz/escalate immediately without waiting for an edge.
REQ-031 After rst rises, the first edge with en=1 and alarm=1 SHALL enter ACTIVE.

Verification (TIMEOUT=8, HOLDOFF=4)
REQ-032 Basic acknowledge: alarm high at edge 0, ack pulse at edge 3, alarm low at edge 5 -> buzz high edges 1..3, ACKED at 4, HOLD at 6, IDLE at 10, alarm_cnt=1.
REQ-033 Escalation and tie: no ack -> escalate rises 8 cycles after buzz; in a second run ack coincides with timer==7 -> state ACKED, escalate stays 0.
REQ-034 Latch and retrigger: alarm 1-cycle pulse -> ACTIVE persists until ack; alarm held high through HOLD -> retrigger to ACTIVE one edge after IDLE, alarm_cnt=2.
REQ-035 Counter bounds: 256 alarm cycles -> alarm_cnt=255; clr_cnt coincident with an alarm trigger -> alarm_cnt=0, state ACTIVE.
REQ-036 Control overrides: en=0 during ESCAL -> IDLE next edge, alarm_cnt unchanged; rst=0 mid-clock during ACTIVE -> buzz=0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/alarm_ctrl.sv
// Alarm annunciator controller: latches an alarm until acknowledged, escalates
// on timeout, then holds off re-arming for a fixed interval.
module alarm_ctrl #(
  parameter int unsigned TIMEOUT = 100,
  parameter int unsigned HOLDOFF = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alarm,
  input  logic       ack,
  input  logic       en,
  input  logic       clr_cnt,
  output logic       buzz,
  output logic       escalate,
  output logic [7:0] alarm_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACTIVE = 3'd1,
    ESCAL  = 3'd2,
    ACKED  = 3'd3,
    HOLD   = 3'd4
  } st_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] HO_LAST = 16'(HOLDOFF - 1);

  st_t         cur, nxt;
  logic [15:0] timer;
  logic        raise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur <= IDLE;
    else      cur <= nxt;
  end

  // ack beats timeout in ACTIVE, so escalate never shows on a tie
  always_comb begin
    nxt   = cur;
    raise = 1'b0;
    if (!en) begin
      nxt = IDLE;
    end else begin
      case (cur)
        IDLE: begin
          if (alarm) begin
            nxt   = ACTIVE;
            raise = 1'b1;
          end
        end
        ACTIVE: begin
          if (ack)                  nxt = ACKED;
          else if (timer == TO_LAST) nxt = ESCAL;
        end
        ESCAL:   if (ack)             nxt = ACKED;
        ACKED:   if (!alarm)          nxt = HOLD;
        HOLD:    if (timer == HO_LAST) nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    buzz     = (cur == ACTIVE) || (cur == ESCAL);
    escalate = (cur == ESCAL);
    state    = cur;
  end

  // one timer serves both the ACTIVE timeout and the HOLD interval
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         timer <= '0;
    else if (!en || nxt != cur)       timer <= '0;
    else if (cur == ACTIVE || cur == HOLD) timer <= timer + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             alarm_cnt <= '0;
    else if (clr_cnt)                     alarm_cnt <= '0;
    else if (raise && alarm_cnt != 8'hFF) alarm_cnt <= alarm_cnt + 8'd1;
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: a timestamp-based reference model pushes the
// expected outputs per edge; a negedge monitor pops and compares.
module tb_alarm_ctrl;
  localparam int TO = 8;
  localparam int HO = 4;
  localparam int S_IDLE = 0, S_ACTIVE = 1, S_ESCAL = 2, S_ACKED = 3, S_HOLD = 4;

  logic       clk = 1'b0, rst = 1'b0;
  logic       alarm = 1'b0, ack = 1'b0, en = 1'b0, clr_cnt = 1'b0;
  logic       buzz, escalate;
  logic [7:0] alarm_cnt;
  logic [2:0] state;

  alarm_ctrl #(.TIMEOUT(TO), .HOLDOFF(HO)) dut (
    .clk(clk), .rst(rst), .alarm(alarm), .ack(ack), .en(en), .clr_cnt(clr_cnt),
    .buzz(buzz), .escalate(escalate), .alarm_cnt(alarm_cnt), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int bz;
    int es;
    int cnt;
  } exp_t;

  exp_t sbq[$];
  int checks = 0, errors = 0;
  int m_st = S_IDLE, m_enter = 0, m_cnt = 0, cyc = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endfunction

  // Model: time spent in a state is measured from the edge it was entered.
  task automatic model_edge();
    int   ns = m_st;
    bit   rs = 1'b0;
    exp_t e;
    cyc++;
    if (!en) ns = S_IDLE;
    else case (m_st)
      S_IDLE:   if (alarm) begin ns = S_ACTIVE; rs = 1'b1; end
      S_ACTIVE: if (ack) ns = S_ACKED; else if (cyc - m_enter == TO) ns = S_ESCAL;
      S_ESCAL:  if (ack) ns = S_ACKED;
      S_ACKED:  if (!alarm) ns = S_HOLD;
      S_HOLD:   if (cyc - m_enter == HO) ns = S_IDLE;
      default:  ns = S_IDLE;
    endcase
    if (clr_cnt)  m_cnt = 0;
    else if (rs)  m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
    if (ns != m_st) m_enter = cyc;
    m_st  = ns;
    e.st  = m_st;
    e.bz  = (m_st == S_ACTIVE || m_st == S_ESCAL) ? 1 : 0;
    e.es  = (m_st == S_ESCAL) ? 1 : 0;
    e.cnt = m_cnt;
    sbq.push_back(e);
  endtask

  task automatic step(input logic a, input logic k, input logic e, input logic c);
    alarm = a; ack = k; en = e; clr_cnt = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic async_reset();
    #1 rst = 1'b0;
    sbq.delete();
    #1;
    chk("rst_buzz", buzz, 0);
    chk("rst_escalate", escalate, 0);
    chk("rst_state", state, S_IDLE);
    chk("rst_cnt", alarm_cnt, 0);
    m_st = S_IDLE; m_cnt = 0; m_enter = cyc;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("sb_state", state, e.st);
      chk("sb_buzz", buzz, e.bz);
      chk("sb_escalate", escalate, e.es);
      chk("sb_cnt", alarm_cnt, e.cnt);
    end
  end

  initial begin
    #1;
    chk("init_state", state, S_IDLE);
    chk("init_buzz", buzz, 0);
    chk("init_cnt", alarm_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // basic acknowledge
    step(1, 0, 1, 0);
    chk("basic_buzz", buzz, 1);
    step(1, 0, 1, 0); step(1, 0, 1, 0); step(1, 1, 1, 0);
    chk("basic_acked", state, S_ACKED);
    step(1, 0, 1, 0); step(0, 0, 1, 0);
    chk("basic_hold", state, S_HOLD);
    repeat (4) step(0, 0, 1, 0);
    chk("basic_idle", state, S_IDLE);
    chk("basic_cnt", alarm_cnt, 1);

    // escalation via a 1-cycle alarm pulse (latched ACTIVE)
    step(1, 0, 1, 0);
    repeat (7) step(0, 0, 1, 0);
    chk("esc_not_yet", escalate, 0);
    chk("latch_active", state, S_ACTIVE);
    step(0, 0, 1, 0);
    chk("esc_rise", escalate, 1);
    step(0, 0, 0, 0);
    chk("en_off_idle", state, S_IDLE);
    chk("en_off_cnt", alarm_cnt, 2);

    // ack coincident with the timeout edge
    step(1, 0, 1, 0);
    repeat (7) step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    chk("tie_state", state, S_ACKED);
    chk("tie_escalate", escalate, 0);

    // alarm held high through HOLD retriggers
    step(0, 0, 1, 0);
    repeat (4) step(1, 0, 1, 0);
    chk("retrig_idle", state, S_IDLE);
    step(1, 0, 1, 0);
    chk("retrig_active", state, S_ACTIVE);
    chk("retrig_cnt", alarm_cnt, 4);
    step(0, 0, 0, 0);

    // saturation, then clear beating a simultaneous raise
    repeat (260) begin step(1, 0, 1, 0); step(1, 0, 0, 0); end
    chk("sat_cnt", alarm_cnt, 255);
    step(1, 0, 1, 1);
    chk("clr_cnt", alarm_cnt, 0);
    chk("clr_state", state, S_ACTIVE);

    // asynchronous reset mid-ACTIVE
    async_reset();
    step(1, 0, 1, 0);
    chk("post_rst_active", state, S_ACTIVE);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
           $urandom_range(0, 19) != 0, $urandom_range(0, 49) == 0);
      if (i % 700 == 699) async_reset();
    end

    @(negedge clk);
    #1;
    chk("sb_drain", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
